// File: rtl/uart_mmio_bridge_pkg.sv
// Shared definitions for the UART MMIO bridge: register offsets, STATUS/CTRL bit positions
// and the address decoder used by the top level.
package uart_mmio_bridge_pkg;

    localparam logic [27:0] OffStatus = 28'h00;
    localparam logic [27:0] OffRxData = 28'h04;
    localparam logic [27:0] OffTxData = 28'h08;
    localparam logic [27:0] OffCycles = 28'h10;
    localparam logic [27:0] OffCtrl   = 28'h18;

    localparam int unsigned StatTxReady   = 0;
    localparam int unsigned StatRxValid   = 1;
    localparam int unsigned StatTxOverrun = 2;
    localparam int unsigned StatCountLsb  = 4;

    localparam int unsigned CtrlClrCycles  = 0;
    localparam int unsigned CtrlClrOverrun = 1;

    typedef enum logic [2:0] {
        RegNone,
        RegStatus,
        RegRxData,
        RegTxData,
        RegCycles,
        RegCtrl
    } reg_sel_e;

    // Window selected by addr[31:28]; offsets must match exactly, so aliases read as unmapped.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [3:0] base_nib);
        reg_sel_e sel;
        sel = RegNone;
        if (addr[31:28] == base_nib) begin
            case (addr[27:0])
                OffStatus: sel = RegStatus;
                OffRxData: sel = RegRxData;
                OffTxData: sel = RegTxData;
                OffCycles: sel = RegCycles;
                OffCtrl:   sel = RegCtrl;
                default:   sel = RegNone;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full, pop when empty.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// MMIO bridge between the CPU data port and the UART byte streams: RX FIFO, TX holding
// register, free-running cycle counter and a registered read mux.
module uart_mmio_bridge
    import uart_mmio_bridge_pkg::*;
#(
    parameter int unsigned RX_DEPTH  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        wr_en_i,
    input  logic        rd_en_i,
    output logic [31:0] rd_data_o,
    output logic [7:0]  uart_data_in_o,
    output logic        uart_data_in_valid_o,
    input  logic        uart_data_in_ready_i,
    input  logic [7:0]  uart_data_out_i,
    input  logic        uart_data_out_valid_i,
    output logic        uart_data_out_ready_o
);

    localparam int unsigned CntW = $clog2(RX_DEPTH) + 1;

    reg_sel_e        sel;
    logic            rd_act, tx_wr, ctrl_wr, tx_release;
    logic            rx_push, rx_pop;
    logic [7:0]      fifo_data;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [31:0]     cnt_ext;
    logic [3:0]      cnt_sat;
    logic [31:0]     status;
    logic [31:0]     rd_mux;

    logic [31:0] rd_data_q, rd_data_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_ovr_q, tx_ovr_d;
    logic [31:0] cycles_q, cycles_d;

    logic unused_wdata;
    assign unused_wdata = ^wr_data_i[31:8];

    assign sel     = decode_addr(addr_i, BASE_ADDR[31:28]);
    // A write wins over a read in the (illegal) case both strobes are high.
    assign rd_act  = rd_en_i && !wr_en_i;
    assign tx_wr   = wr_en_i && (sel == RegTxData);
    assign ctrl_wr = wr_en_i && (sel == RegCtrl);

    assign tx_release = tx_valid_q && uart_data_in_ready_i;
    assign rx_push    = uart_data_out_valid_i && !fifo_full;
    assign rx_pop     = rd_act && (sel == RegRxData) && !fifo_empty;

    sync_fifo #(
        .Width (8),
        .Depth (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_push),
        .data_i  (uart_data_out_i),
        .pop_i   (rx_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign cnt_ext = 32'(fifo_count);
    assign cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];

    always_comb begin
        status                      = '0;
        status[StatTxReady]         = !tx_valid_q;
        status[StatRxValid]         = !fifo_empty;
        status[StatTxOverrun]       = tx_ovr_q;
        status[StatCountLsb +: 4]   = cnt_sat;
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            RegStatus: rd_mux = status;
            RegRxData: rd_mux = fifo_empty ? 32'h0 : {24'h0, fifo_data};
            RegCycles: rd_mux = cycles_q;
            default:   rd_mux = '0;
        endcase
        rd_data_d = rd_act ? rd_mux : rd_data_q;
    end

    // The holding register is still full at the edge where it is released, so a
    // coincident write is dropped and flagged.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_ovr_d   = tx_ovr_q;
        if (tx_wr) begin
            if (tx_valid_q) begin
                tx_ovr_d = 1'b1;
            end else begin
                tx_valid_d = 1'b1;
                tx_data_d  = wr_data_i[7:0];
            end
        end
        if (tx_release) tx_valid_d = 1'b0;
        if (ctrl_wr && wr_data_i[CtrlClrOverrun]) tx_ovr_d = 1'b0;
    end

    assign cycles_d = (ctrl_wr && wr_data_i[CtrlClrCycles]) ? 32'h0 : cycles_q + 32'h1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_ovr_q   <= 1'b0;
            cycles_q   <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_ovr_q   <= tx_ovr_d;
            cycles_q   <= cycles_d;
        end
    end

    assign rd_data_o             = rd_data_q;
    assign uart_data_in_o        = tx_data_q;
    assign uart_data_in_valid_o  = tx_valid_q;
    assign uart_data_out_ready_o = !fifo_full;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed and randomized bench for uart_mmio_bridge against a queue-based reference model.
module tb_uart_mmio_bridge;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = BASE + 32'h00;
    localparam logic [31:0] A_RX     = BASE + 32'h04;
    localparam logic [31:0] A_TX     = BASE + 32'h08;
    localparam logic [31:0] A_CYC    = BASE + 32'h10;
    localparam logic [31:0] A_CTRL   = BASE + 32'h18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    byte unsigned m_q[$];
    bit           m_full;
    logic [7:0]   m_byte;
    bit           m_ovr;
    int unsigned  m_cyc;
    logic [31:0]  m_rd;
    bit           m_pushed;

    always #5 clk = ~clk;

    uart_mmio_bridge #(
        .RX_DEPTH  (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .addr_i                (addr),
        .wr_data_i             (wr_data),
        .wr_en_i               (wr_en),
        .rd_en_i               (rd_en),
        .rd_data_o             (rd_data),
        .uart_data_in_o        (tx_byte),
        .uart_data_in_valid_o  (tx_valid),
        .uart_data_in_ready_i  (tx_ready),
        .uart_data_out_i       (rx_byte),
        .uart_data_out_valid_i (rx_valid),
        .uart_data_out_ready_o (rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_full   = 0;
        m_byte   = 8'h00;
        m_ovr    = 0;
        m_cyc    = 0;
        m_rd     = 32'h0;
        m_pushed = 0;
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = (m_q.size() > 15) ? 15 : m_q.size();
        return 32'(n) * 16 + (m_ovr ? 4 : 0) + ((m_q.size() != 0) ? 2 : 0) + (m_full ? 0 : 1);
    endfunction

    // Advance the model by one clock using the current inputs, then step the DUT and compare.
    task automatic tick();
        bit was_full, rel, push, pop, clr;
        int sz;
        was_full = m_full;
        sz       = m_q.size();
        rel      = m_full && tx_ready;
        push     = rx_valid && (sz < DEPTH);
        pop      = 0;
        clr      = 0;
        if (rd_en && !wr_en) begin
            if (addr == A_STATUS) m_rd = model_status();
            else if (addr == A_RX) begin
                if (sz > 0) begin
                    m_rd = {24'h0, m_q[0]};
                    pop  = 1;
                end else m_rd = 32'h0;
            end else if (addr == A_CYC) m_rd = m_cyc;
            else m_rd = 32'h0;
        end
        if (wr_en) begin
            if (addr == A_TX) begin
                if (was_full) m_ovr = 1;
                else begin
                    m_full = 1;
                    m_byte = wr_data[7:0];
                end
            end else if (addr == A_CTRL) begin
                if (wr_data[0]) clr = 1;
                if (wr_data[1]) m_ovr = 0;
            end
        end
        if (rel) m_full = 0;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(rx_byte);
        m_cyc    = clr ? 0 : m_cyc + 1;
        m_pushed = push;
        @(posedge clk);
        #1;
        check("rd_data", rd_data, m_rd);
        check("tx_valid", 32'(tx_valid), 32'(m_full));
        if (m_full) check("tx_byte", 32'(tx_byte), 32'(m_byte));
        check("rx_ready", 32'(rx_ready), 32'(m_q.size() < DEPTH));
    endtask

    task automatic do_read(input logic [31:0] a);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    logic [31:0] c1, c2;
    logic [31:0] addr_list [8];

    initial begin
        model_reset();
        addr_list[0] = A_STATUS;
        addr_list[1] = A_RX;
        addr_list[2] = A_TX;
        addr_list[3] = A_CYC;
        addr_list[4] = A_CTRL;
        addr_list[5] = BASE + 32'h0C;
        addr_list[6] = 32'h9000_0004;
        addr_list[7] = BASE + 32'h14;

        // Reset values
        #23;
        check("rst rd_data", rd_data, 32'h0);
        check("rst tx_valid", 32'(tx_valid), 32'h0);
        check("rst tx_byte", 32'(tx_byte), 32'h0);
        check("rst rx_ready", 32'(rx_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_read(A_STATUS);
        check("status after reset", rd_data, 32'h0000_0001);
        do_read(A_CYC);
        c1 = rd_data;
        repeat (4) tick();
        do_read(A_CYC);
        c2 = rd_data;
        check("cycles delta", c2 - c1, 32'd5);

        // TX held under backpressure, then released
        tx_ready = 1'b0;
        do_write(A_TX, 32'h0000_007A);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("tx hold", {23'h0, tx_valid, tx_byte}, 32'h17A);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        do_read(A_STATUS);
        check("tx_ready after release", 32'(rd_data[0]), 32'h1);

        // Overrun on back-to-back writes
        do_write(A_TX, 32'h41);
        do_write(A_TX, 32'h42);
        check("overrun keeps first", 32'(tx_byte), 32'h41);
        do_read(A_STATUS);
        check("overrun flag", 32'(rd_data[2]), 32'h1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        do_write(A_CTRL, 32'h2);
        do_read(A_STATUS);
        check("overrun cleared", rd_data, 32'h0000_0001);

        // Fill the RX FIFO with a TX byte pending
        do_write(A_TX, 32'h55);
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'(8'h10 + i);
            tick();
        end
        rx_byte = 8'h18;
        tick();
        check("full rx_ready", 32'(rx_ready), 32'h0);
        do_read(A_STATUS);
        check("status full", rd_data, 32'h0000_0082);
        do_read(A_RX);
        check("first pop", rd_data, 32'h10);
        check("ready after pop", 32'(rx_ready), 32'h1);
        tick();
        rx_valid = 1'b0;
        check("0x18 accepted", 32'(m_pushed), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            do_read(A_RX);
            check("drain order", rd_data, 32'(8'h10 + i));
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // Empty read, then simultaneous push/pop at count 3
        do_read(A_RX);
        check("empty read", rd_data, 32'h0);
        do_read(A_STATUS);
        check("empty count", 32'(rd_data[7:4]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'(8'h21 + i);
            tick();
        end
        rx_byte = 8'h24;
        addr    = A_RX;
        rd_en   = 1'b1;
        tick();
        rd_en    = 1'b0;
        rx_valid = 1'b0;
        check("push+pop head", rd_data, 32'h21);
        do_read(A_STATUS);
        check("push+pop count", 32'(rd_data[7:4]), 32'h3);
        for (int i = 0; i < 3; i++) begin
            do_read(A_RX);
            check("push+pop order", rd_data, 32'(8'h22 + i));
        end

        // Asynchronous reset with TX pending and 4 bytes buffered
        do_write(A_TX, 32'h66);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'(8'hA0 + i);
            tick();
        end
        rx_valid = 1'b0;
        do_read(A_STATUS);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rd_data", rd_data, 32'h0);
        check("async tx_valid", 32'(tx_valid), 32'h0);
        check("async tx_byte", 32'(tx_byte), 32'h0);
        check("async rx_ready", 32'(rx_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_read(A_STATUS);
        check("status after async reset", rd_data, 32'h0000_0001);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int op;
            op    = $urandom_range(0, 9);
            rd_en = 1'b0;
            wr_en = 1'b0;
            if (op <= 2) begin
                rd_en = 1'b1;
                addr  = addr_list[$urandom_range(0, 7)];
            end else if (op <= 4) begin
                wr_en   = 1'b1;
                addr    = addr_list[$urandom_range(0, 7)];
                wr_data = $urandom;
            end
            tx_ready = ($urandom_range(0, 2) == 0);
            if (!rx_valid || m_pushed) begin
                rx_valid = ($urandom_range(0, 2) != 0);
                rx_byte  = 8'($urandom);
            end
            tick();
        end
        rd_en = 1'b0;
        wr_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
